// File: rtl/pixel_scheduler.sv
// pixel_scheduler: round-robin pixel dispatch to NUM_UNITS compute units with in-order AXI4-Stream retire.
// Build option: define PIXSCHED_CONTINUOUS_EN to stream frames back-to-back after a single start.
module pixel_scheduler #(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int NUM_UNITS = 4,
    parameter int XW        = 10
) (
    input  logic                    out_stream_aclk,
    input  logic                    periph_resetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    frame_done,
    output logic [NUM_UNITS-1:0]    unit_req_valid,
    input  logic [NUM_UNITS-1:0]    unit_req_ready,
    output logic [XW-1:0]           unit_req_x,
    output logic [XW-1:0]           unit_req_y,
    input  logic [NUM_UNITS-1:0]    unit_res_valid,
    output logic [NUM_UNITS-1:0]    unit_res_ready,
    input  logic [24*NUM_UNITS-1:0] unit_res_data,
    output logic [31:0]             out_stream_tdata,
    output logic                    out_stream_tvalid,
    input  logic                    out_stream_tready,
    output logic                    out_stream_tuser,
    output logic                    out_stream_tlast,
    output logic [3:0]              out_stream_tkeep
);
    localparam int PW = $clog2(NUM_UNITS);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [XW-1:0] Y_LAST = XW'(Y_SIZE - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_UNITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q;
    logic            frame_done_q;
    logic [PW-1:0]   ip_q, ip_d, rp_q, rp_d;
    logic [XW-1:0]   ix_q, ix_d, iy_q, iy_d;
    logic [XW-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic            go, issuing, active;
    logic            iss_hs, ret_hs, iss_last, ret_last;

    assign go       = (state_q == IDLE) && start;
    assign issuing  = (state_q == RUN);
    assign active   = (state_q != IDLE);
    assign iss_hs   = issuing && unit_req_ready[ip_q];
    assign ret_hs   = active && unit_res_valid[rp_q] && out_stream_tready;
    assign iss_last = iss_hs && (ix_q == X_LAST) && (iy_q == Y_LAST);
    assign ret_last = ret_hs && (ox_q == X_LAST) && (oy_q == Y_LAST);

    assign busy              = active;
    assign frame_done        = frame_done_q;
    assign unit_req_valid    = issuing ? (NUM_UNITS'(1) << ip_q) : '0;
    assign unit_req_x        = ix_q;
    assign unit_req_y        = iy_q;
    assign unit_res_ready    = (active && out_stream_tready) ? (NUM_UNITS'(1) << rp_q) : '0;
    assign out_stream_tvalid = active && unit_res_valid[rp_q];
    assign out_stream_tdata  = active ? {8'h00, unit_res_data[int'(rp_q)*24 +: 24]} : '0;
    assign out_stream_tuser  = active && (ox_q == '0) && (oy_q == '0);
    assign out_stream_tlast  = active && (ox_q == X_LAST);
    assign out_stream_tkeep  = 4'b1111;

    // Pointer and raster advance; a frame start rewinds everything because ip/rp end a frame mid-rotation
    always_comb begin
        ip_d = go ? '0 : iss_hs ? ((ip_q == P_LAST) ? '0 : ip_q + 1'b1) : ip_q;
        ix_d = go ? '0 : iss_hs ? ((ix_q == X_LAST) ? '0 : ix_q + 1'b1) : ix_q;
        iy_d = go ? '0 : (iss_hs && ix_q == X_LAST) ? ((iy_q == Y_LAST) ? '0 : iy_q + 1'b1) : iy_q;
        rp_d = go ? '0 : ret_hs ? ((rp_q == P_LAST) ? '0 : rp_q + 1'b1) : rp_q;
        ox_d = go ? '0 : ret_hs ? ((ox_q == X_LAST) ? '0 : ox_q + 1'b1) : ox_q;
        oy_d = go ? '0 : (ret_hs && ox_q == X_LAST) ? ((oy_q == Y_LAST) ? '0 : oy_q + 1'b1) : oy_q;
    end

    // Issue and retire position registers
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            ip_q <= '0;
            ix_q <= '0;
            iy_q <= '0;
            rp_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            ip_q <= ip_d;
            ix_q <= ix_d;
            iy_q <= iy_d;
            rp_q <= rp_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    // Frame control: start, end of issue, end of retire, and the done pulse on the last retire
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= ret_last;
            case (state_q)
                IDLE:    if (start) state_q <= RUN;
`ifdef PIXSCHED_CONTINUOUS_EN
                RUN:     state_q <= RUN;
`else
                RUN:     if (iss_last) state_q <= DRAIN;
`endif
                DRAIN:   if (ret_last) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: directed checks of dispatch order, in-order retire, backpressure, stalls and reset.
module tb_pixel_scheduler;
    localparam int X  = 4;
    localparam int Y  = 2;
    localparam int N  = 3;
    localparam int XW = 10;
`ifdef PIXSCHED_CONTINUOUS_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, frame_done;
    logic [N-1:0]    req_valid, req_ready, res_valid, res_ready;
    logic [XW-1:0]   req_x, req_y;
    logic [24*N-1:0] res_data;
    logic [31:0]     tdata;
    logic            tvalid, tready, tuser, tlast;
    logic [3:0]      tkeep;

    int n_checks = 0;
    int n_errors = 0;
    int lat [N];
    logic [N-1:0] stall = '0;
    logic bp_en = 1'b0;
    logic ooo_chk = 1'b0;
    logic stall_chk = 1'b0;

    logic u_busy [N];
    int   u_cnt  [N];
    logic [23:0] u_dat [N];
    int   cyc;
    logic [3:0] bp_pat = 4'b1001;

    int   beat = 0;
    int   fd_cnt = 0;
    logic acc0 = 1'b0;
    logic hold_pend = 1'b0;

    always #5 clk = ~clk;

    pixel_scheduler #(.X_SIZE(X), .Y_SIZE(Y), .NUM_UNITS(N), .XW(XW)) dut (
        .out_stream_aclk(clk),
        .periph_resetn(rst_n),
        .start(start),
        .busy(busy),
        .frame_done(frame_done),
        .unit_req_valid(req_valid),
        .unit_req_ready(req_ready),
        .unit_req_x(req_x),
        .unit_req_y(req_y),
        .unit_res_valid(res_valid),
        .unit_res_ready(res_ready),
        .unit_res_data(res_data),
        .out_stream_tdata(tdata),
        .out_stream_tvalid(tvalid),
        .out_stream_tready(tready),
        .out_stream_tuser(tuser),
        .out_stream_tlast(tlast),
        .out_stream_tkeep(tkeep)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int b);
        int p;
        p = b % (X * Y);
        return {8'h00, 8'(p % X), 8'(p / X), 8'h5A};
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_unit
        assign req_ready[g] = !u_busy[g] && !stall[g];
        assign res_valid[g] = u_busy[g] && (u_cnt[g] == 0);
        assign res_data[24*g +: 24] = u_dat[g];
    end

    // Compute unit models: one outstanding pixel each, fixed latency, result held until taken
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                u_busy[k] <= 1'b0;
                u_cnt[k]  <= 0;
                u_dat[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    u_busy[k] <= 1'b1;
                    u_cnt[k]  <= lat[k];
                    u_dat[k]  <= {req_x[7:0], req_y[7:0], 8'h5A};
                end else if (res_valid[k] && res_ready[k]) begin
                    u_busy[k] <= 1'b0;
                end else if (u_busy[k] && u_cnt[k] != 0) begin
                    u_cnt[k] <= u_cnt[k] - 1;
                end
            end
        end
    end

    // Sink ready: always 1, or the repeating 1,0,0,1 pattern
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready <= 1'b1;
            cyc    <= 0;
        end else begin
            cyc    <= cyc + 1;
            tready <= bp_en ? bp_pat[cyc % 4] : 1'b1;
        end
    end

    // Stream monitor sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (start && !busy) begin
                beat   = 0;
                fd_cnt = 0;
                acc0   = 1'b0;
            end
            if (ooo_chk && beat < 2) check("res_rdy2_wait", 32'(res_ready[2]), 0);
            if (stall_chk && busy && !acc0) begin
                check("no_skip", 32'(req_valid[1]), 0);
                check("stall_coord", 32'({req_x, req_y}), 0);
            end
            if (req_valid[0] && req_ready[0]) acc0 = 1'b1;
            if (hold_pend) check("hold_valid", 32'(tvalid), 1);
            if (tvalid) begin
                check("tdata", tdata, exp_pix(beat));
                check("tuser", 32'(tuser), 32'((beat % (X * Y)) == 0));
                check("tlast", 32'(tlast), 32'((beat % X) == X - 1));
            end
            hold_pend = tvalid && !tready;
            if (tvalid && tready) beat++;
            if (frame_done) begin
                fd_cnt++;
                check("busy_at_done", 32'(busy), 32'(CONT));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_rise", 32'(busy), 1);
        check("req_first", 32'(req_valid), 1);
        check("req_xy0", 32'({req_x, req_y}), 0);
    endtask

    task automatic run_frame(input int stall_cyc, input int restart_at);
        int c;
        c = 0;
        pulse_start();
        if (stall_cyc > 0) begin
            repeat (stall_cyc) @(posedge clk);
            #1 stall = '0;
        end
        if (restart_at > 0) begin
            repeat (restart_at) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        while (fd_cnt == 0 && c < 400) begin
            @(negedge clk);
            #1 c++;
        end
        check("frame_done_seen", 32'(fd_cnt != 0), 1);
        repeat (4) @(negedge clk);
        #1;
        check("beats", beat, X * Y);
        check("fd_pulses", fd_cnt, 1);
        check("busy_end", 32'(busy), 0);
    endtask

    initial begin
        lat = '{2, 2, 2};
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_req", 32'(req_valid), 0);
        check("rst_resrdy", 32'(res_ready), 0);
        check("rst_tvalid", 32'(tvalid), 0);
        check("rst_tuser", 32'(tuser), 0);
        check("rst_tlast", 32'(tlast), 0);
        check("tkeep", 32'(tkeep), 32'hF);
        rst_n = 1'b1;
`ifdef PIXSCHED_CONTINUOUS_EN
        begin
            int c;
            c = 0;
            pulse_start();
            while (fd_cnt < 3 && c < 1000) begin
                @(negedge clk);
                #1 c++;
            end
            check("cont_fd3", fd_cnt, 3);
            check("cont_beats", 32'(beat >= 3 * X * Y), 1);
            check("cont_busy", 32'(busy), 1);
            repeat (10) @(negedge clk);
            #1;
            check("cont_busy_late", 32'(busy), 1);
        end
`else
        run_frame(0, 0);
        lat = '{1, 10, 1};
        ooo_chk = 1'b1;
        run_frame(0, 0);
        ooo_chk = 1'b0;
        lat = '{2, 2, 2};
        bp_en = 1'b1;
        run_frame(0, 0);
        bp_en = 1'b0;
        stall = 3'b001;
        stall_chk = 1'b1;
        run_frame(5, 0);
        stall_chk = 1'b0;
        run_frame(0, 3);
        pulse_start();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(frame_done), 0);
        check("abort_req", 32'(req_valid), 0);
        check("abort_resrdy", 32'(res_ready), 0);
        check("abort_tvalid", 32'(tvalid), 0);
        check("abort_tuser", 32'(tuser), 0);
        check("abort_tlast", 32'(tlast), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pixel_scheduler.md
# pixel_scheduler

Dispatch and reorder controller between the fractal compute units and the video output stream. It walks the frame in raster order and hands pixel coordinates round-robin to `NUM_UNITS` parallel compute units. It collects their results in issue order and emits them as an AXI4-Stream video stream with `tuser` at start of frame and `tlast` at end of line. It replaces the single-engine pixel counter path in the parallel build.

## Interface
Parameters:
- `X_SIZE`, 640: pixels per line.
- `Y_SIZE`, 480: lines per frame.
- `NUM_UNITS`, 4: number of compute units, 2..16.
- `XW`, 10: coordinate width in bits; must hold X_SIZE-1 and Y_SIZE-1.

Ports:
- `out_stream_aclk`, in, 1: the single clock.
- `periph_resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins a frame.
- `busy`, out, 1: high while a frame is in progress.
- `frame_done`, out, 1: one-cycle pulse when the last pixel of a frame is retired.
- `unit_req_valid`, out, NUM_UNITS: one-hot request strobe.
- `unit_req_ready`, in, NUM_UNITS: high means the unit is idle and can accept a request.
- `unit_req_x`, `unit_req_y`, out, XW: broadcast pixel coordinates.
- `unit_res_valid`, in, NUM_UNITS: result available per unit.
- `unit_res_ready`, out, NUM_UNITS: one-hot result accept.
- `unit_res_data`, in, 24*NUM_UNITS: RGB result per unit; unit k occupies bits [24k+23:24k].
- `out_stream_tdata`, out, 32: output pixel, formatted as {8'h00, rgb}.
- `out_stream_tvalid`, out, 1: stream valid.
- `out_stream_tready`, in, 1: stream ready.
- `out_stream_tuser`, out, 1: start of frame.
- `out_stream_tlast`, out, 1: end of line.
- `out_stream_tkeep`, out, 4: constant 4'b1111.

## Operation
State machine:
- IDLE -> RUN on `start`.
- RUN -> DRAIN once the last pixel (X_SIZE-1, Y_SIZE-1) is issued.
- DRAIN -> IDLE when the last pixel is retired; `frame_done` pulses on that cycle.

Issue side:
- Registers: issue pointer `ip`, raster counters `ix`/`iy`.
- In RUN, `unit_req_valid` = one-hot(`ip`), with `unit_req_x`/`unit_req_y` = `ix`/`iy`.
- Valid never depends on `unit_req_ready`.
- A handshake is `unit_req_valid[ip] & unit_req_ready[ip]`. On a handshake:
  - `ip` increments modulo NUM_UNITS.
  - `ix` increments; at X_SIZE-1 it wraps to 0 and `iy` increments.
- If the current unit is not ready, the scheduler stalls on that unit and never skips it. This keeps issue order strictly round-robin, so retire order is implied.
- Each unit holds at most one outstanding pixel.

Retire side:
- Registers: retire pointer `rp`, output counters `ox`/`oy`.
- In RUN or DRAIN:
  - `out_stream_tvalid` = `unit_res_valid[rp]`.
  - `out_stream_tdata` = {8'h00, unit_res_data[rp]}.
  - `unit_res_ready` = one-hot(`rp`) & `out_stream_tready`.
- On a stream handshake, `rp`, `ox` and `oy` advance, with the same wrap rules as the issue side.
- `out_stream_tuser` = (`ox`==0 && `oy`==0).
- `out_stream_tlast` = (`ox`==X_SIZE-1).
- Results from units other than `rp` wait and are never dropped.

Boundary conditions:
- `start` while `busy` is ignored.
- Issue and retire handshakes in the same cycle are independent and both take effect.
- A frame with fewer pixels than NUM_UNITS is legal.
- Asserting `periph_resetn` mid-frame aborts immediately. The compute units share the same reset, so no stale results survive.

## Timing
Reset values:
- State = IDLE.
- All pointers and counters = 0.
- `busy`, `frame_done`, `unit_req_valid`, `unit_res_ready`, `out_stream_tvalid` = 0.
- `out_stream_tuser` and `out_stream_tlast` are forced to 0 in IDLE.

Latency and cadence:
- `start` sampled at edge N: state = RUN and `busy`=1 after edge N, so the first `unit_req_valid` appears in cycle N+1.
- Request and result paths are zero latency (combinational from registered state); pointers update on the handshake edge.
- `busy` falls on the same edge that raises `frame_done`.
- Peak throughput is one issue and one retire per cycle.

## Configuration
Macro `PIXSCHED_CONTINUOUS_EN`:
- When defined:
  - After the last pixel is issued, RUN wraps `ix`/`iy` to 0 and keeps issuing the next frame. DRAIN is never entered.
  - `frame_done` pulses at each frame's last retire.
  - `busy` stays 1 until reset.
  - `start` is needed only once.
- When undefined: single-frame behaviour as described in Operation.

## Test plan
Unless noted, the bench uses X_SIZE=4, Y_SIZE=2, NUM_UNITS=3.

- **Basic frame:** units always ready with 2-cycle latency, tready=1, `start` pulse.
  - Exactly 8 beats are emitted in raster order; data = {8'h00, x, y-coded rgb}.
  - tuser is set on beat 0 only; tlast is set on beats 3 and 7.
  - A single `frame_done` pulse occurs, then `busy`=0.
- **Out-of-order completion:** unit 1 latency 10, units 0 and 2 latency 1.
  - Output order is still 0..7.
  - `unit_res_ready[2]` stays 0 until unit 1's result is taken.
- **Backpressure:** tready toggles 1,0,0,1 repeatedly.
  - tdata and tvalid are held stable while tready=0.
  - No beat is lost or duplicated; 8 beats total.
- **Unit stall:** `unit_req_ready[0]` is held low for 5 cycles at the start.
  - No request goes to unit 1 before unit 0 accepts pixel (0,0).
- **Reset and start while busy:**
  - `start` re-pulsed mid-frame is ignored, giving 8 beats total.
  - `periph_resetn` dropped mid-frame gives all outputs at reset values in the same cycle.
  - A fresh `start` after reset yields a complete frame from (0,0).
- **Continuous mode:** with `PIXSCHED_CONTINUOUS_EN` defined.
  - 3 frames stream back-to-back, tuser every 8 beats.
  - 3 `frame_done` pulses occur; `busy` stays 1.
